serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Multi-cycle WIDTH-bit subtractor for the ALU's SUB/SBB/CMP/NEG/DEC path; the borrow-chain counterpart of the ripple adder.
Processes STEP bits per clock through a chain of full subtractors, with the borrow held in a register between steps.
Produces the difference plus the 8086 arithmetic flags CF, OF, ZF, SF, AF and PF.
Uses a start/busy/done handshake with the control unit's execute sequencer.

Parameters:
WIDTH, 16, operand width; 8 or 16 are used.
STEP, 4, bits processed per cycle; must divide WIDTH and must be at least 4 so that AF is taken from bit 3 in step 0.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on the rising edge, honoured only in IDLE or DONE
a  input  WIDTH  minuend, captured when start is honoured
b  input  WIDTH  subtrahend, captured when start is honoured
borrow_in  input  1  SBB borrow, captured when start is honoured (0 for SUB/CMP)
busy  output  1  high in RUN
done  output  1  one-cycle pulse; results are valid from this cycle
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
cf  output  1  borrow out of the MSB
of  output  1  signed overflow
zf  output  1  diff == 0
sf  output  1  diff[WIDTH-1]
af  output  1  borrow out of bit 3
pf  output  1  1 when diff[7:0] has an even number of ones

Behaviour:
- Reset (async, rst_n low): state IDLE, step counter 0. busy, done, diff and all flags are 0. Operand registers are cleared.
- Reset asserted mid-operation aborts the operation. No done pulse is issued afterwards.
- States:
  - IDLE: start=1 -> RUN; capture a, b and borrow_in; borrow register <= borrow_in; counter <= 0.
  - RUN: each cycle compute bits [k*STEP +: STEP]. Store the slice into diff and update the borrow register. When counter == WIDTH/STEP-1 -> DONE; otherwise counter+1.
  - DONE: done=1 for exactly this cycle. start=1 -> RUN with a new capture (back-to-back allowed). Otherwise -> IDLE.
- Latency: start sampled at edge 0. RUN occupies edges 1..N, where N = WIDTH/STEP. done is high in the cycle after edge N+1. Defaults give 4 RUN cycles.
- start in RUN is ignored. It is not queued.
- Changes on a, b or borrow_in after capture have no effect.
- diff is written slice by slice during RUN. Intermediate diff values are not valid; consumers use done.
- Flags are updated on the edge that enters DONE:
  - cf = final borrow.
  - of = borrow into bit WIDTH-1 XOR borrow out of bit WIDTH-1.
  - af = borrow out of bit 3, latched during step 0.
  - zf, sf and pf are computed from the complete diff.
- diff and flags hold in IDLE until the next operation reaches DONE.
- Arithmetic: full subtractor per bit: d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).

Decomposition:
- Shared header (`define guarded, included by the ALU files):
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - flag bit positions CF=0, PF=2, AF=4, ZF=6, SF=7, OF=11 for packing into FLAGS.
- One natural sub-module: full_subtractor (Diff, Bout, A, B, Bin). It is instantiated STEP times with the borrow chained through the instances.

Test Plan:
- WIDTH=16: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, cf=1, of=0, zf=0, sf=1, af=1, pf=1; done exactly 5 cycles after the start edge; busy high for 4 cycles.
- a=0x8000, b=0x0001 -> diff=0x7FFF, of=1, cf=0, sf=0, af=1, pf=1.
- a=0x1234, b=0x1234 -> diff=0x0000, zf=1, cf=0, af=0, of=0, pf=1.
- SBB: a=0x0005, b=0x0003, bin=1 -> diff=0x0001, cf=0, af=0, pf=0.
- Start held high through RUN, with a changed mid-run -> first result is unaffected; the second start is accepted only in DONE; back-to-back done pulses are 5 cycles apart.
- rst_n pulsed low during the 2nd RUN cycle -> all outputs 0 immediately, no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the multi-cycle subtractor in the ALU SUB/SBB/CMP/
//   NEG/DEC path.
//   - state_e   : sequencer state encoding (IDLE=0, RUN=1, DONE=2)
//   - FLAG_*    : bit positions of each arithmetic flag inside the 8086 FLAGS
//                 word, used by whoever packs cf/pf/af/zf/sf/of into FLAGS
//   - parity8   : PF helper, 1 when a byte holds an even number of ones
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_OF = 11;

  function automatic logic parity8(input logic [7:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor: computes a - b - bin.
//   Ports:
//     a, b  : operand bits
//     bin   : borrow in from the next lower bit
//     diff  : difference bit
//     bout  : borrow out to the next higher bit
// ---------------------------------------------------------------------------
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow comes in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle WIDTH-bit subtractor producing a - b - borrow_in and the 8086
//   arithmetic flags. STEP bits are computed per clock through a chain of
//   full_subtractor instances; the borrow is carried between steps in a
//   register. STEP must divide WIDTH and be at least 4 so that AF (borrow out
//   of bit 3) is produced during step 0.
//   Ports:
//     clk, rst_n        : clock (rising edge), asynchronous active-low reset
//     start             : request, honoured in IDLE or DONE
//     a, b, borrow_in   : operands, captured when start is honoured
//     busy              : high while the operation is running
//     done              : one-cycle pulse, diff and flags valid from here on
//     diff              : a - b - borrow_in modulo 2^WIDTH
//     cf, of, zf, sf,
//     af, pf            : 8086 arithmetic flags for the subtraction
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             cf,
  output logic             of,
  output logic             zf,
  output logic             sf,
  output logic             af,
  output logic             pf
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

  state_e           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow_reg;
  logic             af_step0_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             cf_reg;
  logic             of_reg;
  logic             zf_reg;
  logic             sf_reg;
  logic             af_reg;
  logic             pf_reg;

  // Current slice of the operands and the borrow chain through it.
  logic [STEP-1:0]  slice_a;
  logic [STEP-1:0]  slice_b;
  logic [STEP-1:0]  slice_d;
  logic [STEP:0]    bchain;
  logic [WIDTH-1:0] diff_next;
  logic             af_final;

  assign slice_a   = a_reg[cnt_reg*STEP +: STEP];
  assign slice_b   = b_reg[cnt_reg*STEP +: STEP];
  assign bchain[0] = borrow_reg;

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_fs
      full_subtractor u_fs (
        .diff (slice_d[gi]),
        .bout (bchain[gi+1]),
        .a    (slice_a[gi]),
        .b    (slice_b[gi]),
        .bin  (bchain[gi])
      );
    end
  endgenerate

  // diff with the current slice merged in; on the last step this is the
  // complete result used for ZF/SF/PF.
  always_comb begin
    diff_next = diff_reg;
    diff_next[cnt_reg*STEP +: STEP] = slice_d;
  end

  // With a single step the bit-3 borrow is only available combinationally.
  assign af_final = (cnt_reg == '0) ? bchain[4] : af_step0_reg;

  // busy/done are registered from the state, so they trail it by one cycle:
  // busy covers the N RUN cycles as seen by the sequencer and done appears
  // once the flags have settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      borrow_reg   <= 1'b0;
      af_step0_reg <= 1'b0;
      diff_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cf_reg       <= 1'b0;
      of_reg       <= 1'b0;
      zf_reg       <= 1'b0;
      sf_reg       <= 1'b0;
      af_reg       <= 1'b0;
      pf_reg       <= 1'b0;
    end else begin
      busy_reg <= (state_reg == RUN);
      done_reg <= (state_reg == DONE);
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= borrow_in;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end else begin
            state_reg  <= IDLE;
          end
        end
        RUN: begin
          diff_reg   <= diff_next;
          borrow_reg <= bchain[STEP];
          if (cnt_reg == '0) begin
            af_step0_reg <= bchain[4];
          end
          if (cnt_reg == LAST_STEP) begin
            cf_reg    <= bchain[STEP];
            of_reg    <= bchain[STEP] ^ bchain[STEP-1];
            af_reg    <= af_final;
            zf_reg    <= (diff_next == '0);
            sf_reg    <= diff_next[WIDTH-1];
            pf_reg    <= parity8(diff_next[7:0]);
            state_reg <= DONE;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign cf   = cf_reg;
  assign of   = of_reg;
  assign zf   = zf_reg;
  assign sf   = sf_reg;
  assign af   = af_reg;
  assign pf   = pf_reg;

endmodule
